// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Holds the PC, serves words straight
//                from the I-side line buffer on a hit, otherwise issues a
//                single-word imem read, and hands {pc, inst} to the
//                instruction queue over valid/ready. Redirects are accepted
//                in any state; responses belonging to a squashed request
//                are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] linebuffer_line,
  input  logic [31:0]  linebuffer_addr,
  input  logic         linebuffer_valid,
  output logic [31:0]  imem_addr,
  output logic [3:0]   imem_rmask,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_resp,
  output logic         iq_valid,
  input  logic         iq_ready,
  output logic [31:0]  iq_inst,
  output logic [31:0]  iq_pc,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic        w_hit;
  logic [31:0] w_word;
  logic [31:0] w_redirect_pc;
  logic        unused_ok;

  // Low address bits are don't-care: lines are 32-byte aligned, PCs word aligned.
  assign unused_ok     = ^{linebuffer_addr[4:0], redirect_pc[1:0]};
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_hit         = linebuffer_valid && (linebuffer_addr[31:5] == pc_q[31:5]);
  assign w_word        = linebuffer_line[{pc_q[4:2], 5'b00000} +: 32];

  // Next-state logic: redirect wins over everything, then hit/miss/response handling.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    req_addr_d = req_addr_q;
    case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          pc_d = w_redirect_pc;
        end else if (w_hit) begin
          if (iq_ready) pc_d = pc_q + 32'd4;
        end else begin
          req_addr_d = pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = w_redirect_pc;
          // The outstanding read cannot be aborted; drain it unless it completes now.
          state_d = imem_resp ? S_FETCH : S_DROP;
        end else if (imem_resp) begin
          inst_d  = imem_rdata;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (redirect_valid) begin
          pc_d    = w_redirect_pc;
          state_d = S_FETCH;
        end else if (iq_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = w_redirect_pc;
        if (imem_resp) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode; reset forces a quiet, well-defined interface.
  always_comb begin
    iq_valid   = 1'b0;
    iq_inst    = 32'd0;
    iq_pc      = pc_q;
    imem_rmask = 4'h0;
    imem_addr  = pc_q;
    if (!rst) begin
      iq_pc     = RESET_PC;
      imem_addr = RESET_PC;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (w_hit) begin
            iq_valid = !redirect_valid;
            iq_inst  = w_word;
          end else if (!redirect_valid) begin
            // A redirect this cycle would make a fresh request stale at birth.
            imem_rmask = 4'hF;
          end
        end
        S_WAIT: begin
          imem_rmask = 4'hF;
          imem_addr  = req_addr_q;
        end
        S_DELIVER: begin
          iq_valid = !redirect_valid;
          iq_inst  = inst_q;
        end
        S_DROP: begin
          imem_rmask = 4'hF;
          imem_addr  = req_addr_q;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      req_addr_q <= req_addr_d;
    end
  end

endmodule
`default_nettype wire
